// File: rtl/approx_mac_acc_16.sv
// Purpose     : accumulates a stream of unsigned approximate-multiplier products into
//               saturating per-vector sums (dot-product / MAC results).
// Latency     : result registered; visible the cycle after the completing beat is accepted.
// Backpressure: in_ready = !out_valid || out_ready; a held result stalls accumulation.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          product beat handshake
//   in_prod [PROD_W]           unsigned product (zero-extended into the accumulator)
//   in_last                    final term of the current vector
//   out_valid/out_ready        result handshake (result held in output registers)
//   out_acc [ACC_W]            saturated sum of the vector
//   out_len [CNT_W]            number of terms in the vector
//   out_ovf                    sum saturated at some point during the vector
module approx_mac_acc_16 #(
    parameter int PROD_W  = 32,
    parameter int ACC_W   = 40,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_len,
    output logic              out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_acc_q;
    logic [CNT_W-1:0]   out_len_q;
    logic               out_ovf_q;

    logic               fire;
    logic [ACC_W:0]     sum;
    logic               sat;
    logic [ACC_W-1:0]   acc_d;
    logic               ovf_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               complete;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_len   = out_len_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        fire  = in_valid && in_ready;
        // One extra bit catches the carry out of the accumulator.
        sum   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
        // An all-ones accumulator means it already saturated; keep it pinned
        // even when the new product is zero.
        sat   = sum[ACC_W] || (&acc_q);
        acc_d = sat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        ovf_d = ovf_q || sat;
        cnt_d = cnt_q + CNT_W'(1);
        // Single flush even when in_last coincides with the length limit.
        complete = in_last || (cnt_d == CNT_W'(MAX_LEN));
    end

    // FSM, accumulator and output register. DONE accepts beats exactly like
    // IDLE (accumulator already cleared), which gives back-to-back results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_len_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (fire) begin
                if (complete) begin
                    out_valid_q <= 1'b1;
                    out_acc_q   <= acc_d;
                    out_len_q   <= cnt_d;
                    out_ovf_q   <= ovf_d;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    ovf_q       <= 1'b0;
                    state_q     <= DONE;
                end else begin
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_d;
                    ovf_q   <= ovf_d;
                    state_q <= RUN;
                end
            end else if (state_q == DONE) begin
                state_q <= IDLE;
            end
        end
    end

endmodule
